// File: rtl/hs_ram_arbiter.sv
// rtl/hs_ram_arbiter.sv - hands the work-RAM port between the CPU and the hiscore engine
// The CPU is paused and its bus allowed to settle before the mux switches; the port is returned before the pause lifts.
module hs_ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int SETTLE = 2,
  parameter int RD_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              hs_access,
  input  logic              hs_write,
  input  logic [ADDR_W-1:0] hs_address,
  input  logic [7:0]        hs_data_in,
  output logic [7:0]        hs_data_out,
  output logic              hs_ready,
  input  logic              cpu_idle,
  input  logic              user_pause,
  output logic              pause_cpu,
  output logic              ram_sel_hs,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_SETTLE, S_ACCESS, S_WAIT, S_DONE, S_RELEASE
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [3:0] RD_LD     = 4'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              latch;
  logic              pause_q, pause_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic [7:0]        dout_q, dout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      pause_q <= 1'b0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      dout_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      pause_q <= pause_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  // A dropped request before the mux switches aborts straight to RELEASE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      S_IDLE:    if (hs_access) state_d = S_HOLD;
      S_HOLD: begin
        if (!hs_access) state_d = S_RELEASE;
        else if (cpu_idle) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (!hs_access) state_d = S_RELEASE;
        else if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
          latch   = 1'b1;
        end else cnt_d = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        if (wr_q) state_d = S_DONE;
        else begin
          state_d = S_WAIT;
          cnt_d   = RD_LD;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else cnt_d = cnt_q - 4'd1;
      end
      S_DONE: begin
        if (hs_access) begin
          state_d = S_ACCESS;
          latch   = 1'b1;
        end else state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d    = latch ? hs_write : wr_q;
    addr_d  = latch ? hs_address : addr_q;
    din_d   = latch ? hs_data_in : din_q;
    pause_d = (state_d != S_IDLE) | user_pause;
    sel_d   = (state_d == S_ACCESS) | (state_d == S_WAIT) | (state_d == S_DONE);
    we_d    = (state_d == S_ACCESS) & wr_d;
    ready_d = (state_d == S_DONE);
    dout_d  = (state_q == S_WAIT && cnt_q == 4'd0) ? ram_dout : dout_q;
  end

  assign pause_cpu   = pause_q;
  assign ram_sel_hs  = sel_q;
  assign ram_we      = we_q;
  assign hs_ready    = ready_q;
  assign hs_data_out = dout_q;
  assign ram_addr    = addr_q;
  assign ram_din     = din_q;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb/tb_hs_ram_arbiter.sv - scoreboard bench for hs_ram_arbiter with a one-cycle-latency RAM model
module tb_hs_ram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        hs_access = 1'b0;
  logic        hs_write = 1'b0;
  logic [15:0] hs_address = '0;
  logic [7:0]  hs_data_in = '0;
  logic [7:0]  hs_data_out;
  logic        hs_ready;
  logic        cpu_idle = 1'b1;
  logic        user_pause = 1'b0;
  logic        pause_cpu;
  logic        ram_sel_hs;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout = '0;

  hs_ram_arbiter #(.ADDR_W(16), .SETTLE(2), .RD_LAT(1)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .hs_access(hs_access), .hs_write(hs_write), .hs_address(hs_address),
    .hs_data_in(hs_data_in), .hs_data_out(hs_data_out), .hs_ready(hs_ready),
    .cpu_idle(cpu_idle), .user_pause(user_pause), .pause_cpu(pause_cpu),
    .ram_sel_hs(ram_sel_hs), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {int cyc; logic [7:0] data; bit has_data;} rdy_t;
  typedef struct {int cyc; logic [15:0] addr; logic [7:0] din;} we_t;

  rdy_t exp_rdy[$];
  we_t  exp_we[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic [7:0] mem [0:65535];

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion pulse and write strobe must match the next expected entry.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (hs_ready) begin
        if (exp_rdy.size() == 0) chk("unexpected_ready", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          rdy_t r;
          r = exp_rdy.pop_front();
          chk("ready_cycle", 32'(cyc), 32'(r.cyc));
          if (r.has_data) chk("ready_data", 32'(hs_data_out), 32'(r.data));
        end
      end
      if (ram_we) begin
        if (exp_we.size() == 0) chk("unexpected_we", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          we_t w;
          w = exp_we.pop_front();
          chk("we_cycle", 32'(cyc), 32'(w.cyc));
          chk("we_addr", 32'(ram_addr), 32'(w.addr));
          chk("we_din", 32'(ram_din), 32'(w.din));
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic single_read(input logic [15:0] a, input logic [7:0] d, input bit up);
    int t0;
    wait_cyc(1);
    hs_access = 1'b1; hs_write = 1'b0; hs_address = a;
    t0 = cyc;
    exp_rdy.push_back('{t0 + 6, d, 1'b1});
    wait_cyc(3);
    chk("rd_sel_before", 32'(ram_sel_hs), 0);
    chk("rd_pause_hold", 32'(pause_cpu), 1);
    wait_cyc(1);
    chk("rd_sel_rise", 32'(ram_sel_hs), 1);
    wait_cyc(2);
    hs_access = 1'b0;
    chk("rd_data_out", 32'(hs_data_out), 32'(d));
    wait_cyc(1);
    chk("rd_sel_fall", 32'(ram_sel_hs), 0);
    chk("rd_pause_release", 32'(pause_cpu), 1);
    wait_cyc(1);
    chk("rd_pause_end", 32'(pause_cpu), 32'(up));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int  t0;
    bit  ok;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h6010] = 8'hA5;

    wait_cyc(3);
    chk("rst_pause", 32'(pause_cpu), 0);
    chk("rst_sel", 32'(ram_sel_hs), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_ready", 32'(hs_ready), 0);
    chk("rst_dout", 32'(hs_data_out), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    reset_n = 1'b1;

    single_read(16'h6010, 8'hA5, 1'b0);

    // Write burst with the request held throughout.
    wait_cyc(1);
    hs_access = 1'b1; hs_write = 1'b1; hs_address = 16'h6000; hs_data_in = 8'h11;
    t0 = cyc;
    exp_we.push_back('{t0 + 4, 16'h6000, 8'h11});
    exp_we.push_back('{t0 + 6, 16'h6001, 8'h22});
    exp_we.push_back('{t0 + 8, 16'h6002, 8'h33});
    exp_rdy.push_back('{t0 + 5, 8'h00, 1'b0});
    exp_rdy.push_back('{t0 + 7, 8'h00, 1'b0});
    exp_rdy.push_back('{t0 + 9, 8'h00, 1'b0});
    ok = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      wait_cyc(1);
      if (i == 4) begin hs_address = 16'h6001; hs_data_in = 8'h22; end
      if (i == 6) begin hs_address = 16'h6002; hs_data_in = 8'h33; end
      if (i >= 4 && ram_sel_hs !== 1'b1) ok = 1'b0;
      if (pause_cpu !== 1'b1) ok = 1'b0;
      if (i == 9) hs_access = 1'b0;
    end
    chk("burst_sel_pause_window", 32'(ok), 1);
    wait_cyc(1);
    chk("burst_sel_fall", 32'(ram_sel_hs), 0);
    chk("burst_pause_release", 32'(pause_cpu), 1);
    wait_cyc(1);
    chk("burst_pause_end", 32'(pause_cpu), 0);
    chk("burst_mem0", 32'(mem[16'h6000]), 32'h11);
    chk("burst_mem2", 32'(mem[16'h6002]), 32'h33);

    // CPU busy for 20 cycles after the request.
    wait_cyc(1);
    cpu_idle = 1'b0;
    hs_access = 1'b1; hs_write = 1'b0; hs_address = 16'h6010;
    t0 = cyc;
    exp_rdy.push_back('{t0 + 25, 8'hA5, 1'b1});
    ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      wait_cyc(1);
      if (ram_sel_hs !== 1'b0 || pause_cpu !== 1'b1) ok = 1'b0;
    end
    chk("busy_hold", 32'(ok), 1);
    cpu_idle = 1'b1;
    wait_cyc(2);
    chk("busy_sel_settling", 32'(ram_sel_hs), 0);
    wait_cyc(1);
    chk("busy_sel_rise", 32'(ram_sel_hs), 1);
    wait_cyc(2);
    hs_access = 1'b0;
    wait_cyc(2);
    chk("busy_pause_end", 32'(pause_cpu), 0);

    // Request withdrawn while settling.
    wait_cyc(1);
    hs_access = 1'b1; hs_write = 1'b1; hs_address = 16'h7001; hs_data_in = 8'hEE;
    wait_cyc(2);
    hs_access = 1'b0;
    wait_cyc(1);
    chk("abort_pause_release", 32'(pause_cpu), 1);
    chk("abort_sel", 32'(ram_sel_hs), 0);
    wait_cyc(1);
    chk("abort_pause_end", 32'(pause_cpu), 0);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(1);
      if (ram_sel_hs !== 1'b0 || pause_cpu !== 1'b0) ok = 1'b0;
    end
    chk("abort_quiet", 32'(ok), 1);
    chk("abort_no_write", 32'(mem[16'h7001]), 0);

    // User pause held across a whole transaction.
    user_pause = 1'b1;
    single_read(16'h6010, 8'hA5, 1'b1);
    wait_cyc(2);
    chk("upause_still_held", 32'(pause_cpu), 1);
    user_pause = 1'b0;
    wait_cyc(1);
    chk("upause_drop", 32'(pause_cpu), 0);

    // Reset while the write strobe is high.
    wait_cyc(1);
    hs_access = 1'b1; hs_write = 1'b1; hs_address = 16'h7000; hs_data_in = 8'h5A;
    wait_cyc(4);
    chk("midwr_we_high", 32'(ram_we), 1);
    reset_n = 1'b0; hs_access = 1'b0;
    #1;
    chk("midwr_we_async", 32'(ram_we), 0);
    chk("midwr_sel", 32'(ram_sel_hs), 0);
    chk("midwr_pause", 32'(pause_cpu), 0);
    wait_cyc(2);
    reset_n = 1'b1;
    chk("midwr_no_write", 32'(mem[16'h7000]), 0);

    // Reset while waiting on read data.
    wait_cyc(1);
    hs_access = 1'b1; hs_write = 1'b0; hs_address = 16'h6010;
    wait_cyc(5);
    chk("wait_sel_high", 32'(ram_sel_hs), 1);
    reset_n = 1'b0; hs_access = 1'b0;
    #1;
    chk("wait_rst_sel", 32'(ram_sel_hs), 0);
    chk("wait_rst_pause", 32'(pause_cpu), 0);
    chk("wait_rst_ready", 32'(hs_ready), 0);
    chk("wait_rst_dout", 32'(hs_data_out), 0);
    chk("wait_rst_din", 32'(ram_din), 0);
    wait_cyc(2);
    reset_n = 1'b1;

    single_read(16'h6001, 8'h22, 1'b0);

    wait_cyc(3);
    chk("scoreboard_drained", 32'(exp_rdy.size() + exp_we.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
